// File: rtl/regfile_driver_pkg.sv
// rtl/regfile_driver_pkg.sv - opcodes, FSM states and width defaults for regfile_driver
package regfile_driver_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_LI  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WRITE
  } state_e;

endpackage

// File: rtl/regfile_driver_alu.sv
// rtl/regfile_driver_alu.sv - combinational ADD/SUB/AND datapath, results wrap modulo 2^DATA_W
module regfile_driver_alu
  import regfile_driver_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/regfile_driver.sv
// rtl/regfile_driver.sv - IDLE/READ/EXEC/WRITE sequencer driving an external registered-read regfile
// Optional macro RFDRV_R0_ZERO_EN makes register 0 read as zero and ignore writes.
module regfile_driver
  import regfile_driver_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] read_port_1,
  output logic [ADDR_W-1:0] read_port_2,
  output logic [ADDR_W-1:0] write_port_1,
  output logic [DATA_W-1:0] write_data,
  output logic              write_enable,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  state_e            state, state_nxt;
  op_e               op_q, op_nxt;
  logic [ADDR_W-1:0] rd_q, rd_nxt;
  logic [ADDR_W-1:0] rp1_nxt, rp2_nxt, wp_nxt;
  logic [DATA_W-1:0] wd_nxt, result_nxt, opa, opb, alu_y;
  logic              ready_nxt, we_nxt, done_nxt;
  logic              li_rd_zero, alu_rd_zero;

`ifdef RFDRV_R0_ZERO_EN
  // read_port_1/2 still hold rs1/rs2 during EXEC, so they identify the operands
  assign opa         = (read_port_1 == '0) ? '0 : read_data_1;
  assign opb         = (read_port_2 == '0) ? '0 : read_data_2;
  assign li_rd_zero  = (instr_rd == '0);
  assign alu_rd_zero = (rd_q == '0);
`else
  assign opa         = read_data_1;
  assign opb         = read_data_2;
  assign li_rd_zero  = 1'b0;
  assign alu_rd_zero = 1'b0;
`endif

  regfile_driver_alu #(.DATA_W(DATA_W)) u_alu (
    .op (op_q),
    .a  (opa),
    .b  (opb),
    .y  (alu_y)
  );

  always_comb begin
    state_nxt  = state;
    op_nxt     = op_q;
    rd_nxt     = rd_q;
    rp1_nxt    = read_port_1;
    rp2_nxt    = read_port_2;
    wp_nxt     = write_port_1;
    wd_nxt     = write_data;
    result_nxt = result;
    ready_nxt  = 1'b0;
    we_nxt     = 1'b0;
    done_nxt   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        ready_nxt = 1'b1;
        if (instr_valid && instr_ready) begin
          ready_nxt = 1'b0;
          op_nxt    = op_e'(instr_op);
          rd_nxt    = instr_rd;
          if (op_e'(instr_op) == OP_LI) begin
            state_nxt = ST_WRITE;
            we_nxt    = !li_rd_zero;
            wp_nxt    = instr_rd;
            wd_nxt    = li_rd_zero ? '0 : instr_imm;
          end else begin
            state_nxt = ST_READ;
            rp1_nxt   = instr_rs1;
            rp2_nxt   = instr_rs2;
          end
        end
      end
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: begin
        state_nxt = ST_WRITE;
        we_nxt    = !alu_rd_zero;
        wp_nxt    = rd_q;
        wd_nxt    = alu_rd_zero ? '0 : alu_y;
      end
      ST_WRITE: begin
        state_nxt  = ST_IDLE;
        ready_nxt  = 1'b1;
        done_nxt   = 1'b1;
        result_nxt = write_data;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      op_q         <= OP_ADD;
      rd_q         <= '0;
      instr_ready  <= 1'b1;
      read_port_1  <= '0;
      read_port_2  <= '0;
      write_port_1 <= '0;
      write_data   <= '0;
      write_enable <= 1'b0;
      done         <= 1'b0;
      result       <= '0;
    end else begin
      state        <= state_nxt;
      op_q         <= op_nxt;
      rd_q         <= rd_nxt;
      instr_ready  <= ready_nxt;
      read_port_1  <= rp1_nxt;
      read_port_2  <= rp2_nxt;
      write_port_1 <= wp_nxt;
      write_data   <= wd_nxt;
      write_enable <= we_nxt;
      done         <= done_nxt;
      result       <= result_nxt;
    end
  end

endmodule
